lw_sha_wr_admit: RTL and testbench
==================================

Name: lw_sha_wr_admit

Overview:
- Parametrised write-admission stage between the AXI4 slave adapter conduit and the lw_sha control logic.
- Next-generation replacement for the single-cycle reject/overflow check. Writes to backpressured data addresses (DIN, KEY, further channels) are buffered in per-channel FIFOs instead of rejected while the core is busy.
- A slave error is raised only on true buffer overflow.
- Writes to non-channel addresses pass through, registered, to the register block.

Parameters:
DATA_WIDTH, 32, conduit and channel data width (`FIQSHA_BUS in the top).
ADDR_WIDTH, 12, conduit write address width.
NUM_CH, 2, number of buffered channels (>=1).
DEPTH, 4, per-channel FIFO depth; power of 2, >=2.
CH_ADDRS, {12'h040,12'h030}, packed NUM_CH*ADDR_WIDTH; channel i address is CH_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH] (default ch0=0x030 DIN, ch1=0x040 KEY).

Ports:
aclk  in  1  clock; all logic on rising edge.
areset  in  1  synchronous, active-high reset.
wr_i  in  1  conduit write strobe, one word per cycle.
waddr_i  in  ADDR_WIDTH  conduit write address.
wdata_i  in  DATA_WIDTH  conduit write data.
wr_err_o  out  1  slave-error response for the write of the previous cycle.
reg_wr_o  out  1  registered write strobe for non-channel addresses.
reg_waddr_o  out  ADDR_WIDTH  registered address.
reg_wdata_o  out  DATA_WIDTH  registered data.
ch_valid_o  out  NUM_CH  channel i FIFO non-empty.
ch_data_o  out  NUM_CH*DATA_WIDTH  channel i head word.
ch_ready_i  in  NUM_CH  consumer (core ready/key_ready) accepts head.
ch_flush_i  in  NUM_CH  empty channel i (abort/core reset).
ch_level_o  out  NUM_CH*$clog2(DEPTH+1)  channel i occupancy.
ovf_sts_o  out  NUM_CH  sticky overflow flag per channel.
ovf_clr_i  in  NUM_CH  clear ovf_sts_o[i].

Behaviour:
- Reset: all FIFOs empty; wr_err_o, reg_wr_o, reg_waddr_o, reg_wdata_o, ch_valid_o, ch_data_o, ch_level_o and ovf_sts_o are all 0. Reset applies in any state, including mid-burst, and discards buffered data.
- Address decode: the write targets channel i when waddr_i equals channel i's address. If channel addresses are duplicated, the lowest index wins. Any other address is a register write.
- Register write: reg_wr_o/reg_waddr_o/reg_wdata_o equal wr_i/waddr_i/wdata_i delayed by exactly 1 cycle. wr_err_o is 0 for register writes. When no register write occurs, reg_wr_o=0 and address/data hold their last values.
- Channel pop: pop_i = ch_valid_o[i] && ch_ready_i[i]. The head advances on the next edge.
- Channel push: a write to channel i is accepted when level < DEPTH, or when level == DEPTH and pop_i is asserted in the same cycle.
  - Accepted: the word is stored and wr_err_o=0 in the next cycle.
- Overflow: a write to a full channel with no pop in the same cycle is dropped.
  - wr_err_o=1 for exactly 1 cycle in the next cycle.
  - ovf_sts_o[i] is set in that same cycle.
- Latency: there is no bypass. A word pushed into an empty FIFO gives ch_valid_o=1 on the following cycle.
- Level: ch_level_o updates each edge by +1 (push only), -1 (pop only), or 0 (both or neither). Range is 0..DEPTH.
- Pointers: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from the level counter.
- Flush: ch_flush_i[i] empties channel i on the next edge; it has priority over push and pop.
  - A write to channel i in the flush cycle is discarded and wr_err_o=1 next cycle.
  - ovf_sts_o is not changed by flush.
- ovf_sts_o[i] clear: cleared by ovf_clr_i[i]. If a set and a clear occur in the same cycle, the set wins.
- ch_data_o[i] is the storage head. It is undefined-free: it reads 0 after reset and holds its value when the FIFO is empty.
- Channels are fully independent. Pushes and pops on different channels in the same cycle do not interact.

Test Plan:
- Reset with defaults; write 0xA5A5A5A5 to 0x030 -> ch_valid_o[0]=1 after 2 edges, ch_data_o[0]=0xA5A5A5A5, ch_level_o[0]=1, wr_err_o=0.
- ch_ready_i=0; 5 consecutive writes (1..5) to 0x030 -> writes 1-4 accepted, level=4; write 5 gives wr_err_o=1 for one cycle and ovf_sts_o[0]=1. Draining yields exactly 1,2,3,4.
- FIFO full at level 4; write 6 to 0x030 with ch_ready_i[0]=1 in the same cycle -> accepted, wr_err_o=0, level stays 4. The pop order confirms 6 comes after 4, proving pointer wrap.
- Write to 0x010 with data 0x3 -> reg_wr_o=1, reg_waddr_o=0x010, reg_wdata_o=0x3 one cycle later; channel levels unchanged; wr_err_o=0.
- Channel 1 holds 3 words; assert ch_flush_i[1] together with a write to 0x040 -> level 0 next cycle, wr_err_o=1, and channel 0 is unaffected.
- Set ovf_sts_o[0] by overflow, then apply ovf_clr_i[0] in the same cycle as a new overflow -> ovf_sts_o[0] remains 1. Apply a clear alone -> ovf_sts_o[0]=0.

Source files
------------

// File: rtl/lw_sha_wr_admit.sv
// Write-admission stage between the AXI slave conduit and the lw_sha control logic.
// Channel writes are queued in per-channel FIFOs; everything else is forwarded to the register block.
module lw_sha_wr_admit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 4,
    parameter logic [NUM_CH*ADDR_WIDTH-1:0] CH_ADDRS = {12'h040, 12'h030}
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic                               wr_i,
    input  logic [ADDR_WIDTH-1:0]              waddr_i,
    input  logic [DATA_WIDTH-1:0]              wdata_i,
    output logic                               wr_err_o,
    output logic                               reg_wr_o,
    output logic [ADDR_WIDTH-1:0]              reg_waddr_o,
    output logic [DATA_WIDTH-1:0]              reg_wdata_o,
    output logic [NUM_CH-1:0]                  ch_valid_o,
    output logic [NUM_CH*DATA_WIDTH-1:0]       ch_data_o,
    input  logic [NUM_CH-1:0]                  ch_ready_i,
    input  logic [NUM_CH-1:0]                  ch_flush_i,
    output logic [NUM_CH*$clog2(DEPTH+1)-1:0]  ch_level_o,
    output logic [NUM_CH-1:0]                  ovf_sts_o,
    input  logic [NUM_CH-1:0]                  ovf_clr_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [NUM_CH-1:0]     ch_hit;
    logic                  any_hit;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     push;

    logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d    [NUM_CH][DEPTH];
    logic [PW-1:0]         rd_ptr_q [NUM_CH];
    logic [PW-1:0]         rd_ptr_d [NUM_CH];
    logic [PW-1:0]         wr_ptr_q [NUM_CH];
    logic [PW-1:0]         wr_ptr_d [NUM_CH];
    logic [LW-1:0]         level_q  [NUM_CH];
    logic [LW-1:0]         level_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] head_q   [NUM_CH];
    logic [DATA_WIDTH-1:0] head_d   [NUM_CH];
    logic [NUM_CH-1:0]     ovf_q;
    logic [NUM_CH-1:0]     ovf_d;

    logic                  wr_err_q;
    logic                  wr_err_d;
    logic                  reg_wr_q;
    logic                  reg_wr_d;
    logic [ADDR_WIDTH-1:0] reg_waddr_q;
    logic [ADDR_WIDTH-1:0] reg_waddr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q;
    logic [DATA_WIDTH-1:0] reg_wdata_d;

    // Lowest-indexed matching channel claims the write when addresses collide.
    always_comb begin
        ch_hit  = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_i && !any_hit && (waddr_i == CH_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                ch_hit[i] = 1'b1;
                any_hit   = 1'b1;
            end
        end
    end

    always_comb begin
        reg_wr_d    = wr_i && !any_hit;
        reg_waddr_d = reg_wr_d ? waddr_i : reg_waddr_q;
        reg_wdata_d = reg_wr_d ? wdata_i : reg_wdata_q;
    end

    always_comb begin
        wr_err_d = 1'b0;
        pop      = '0;
        push     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_ptr_d[i] = rd_ptr_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            level_d[i]  = level_q[i];
            head_d[i]   = head_q[i];
            mem_d[i]    = mem_q[i];
            ovf_d[i]    = ovf_q[i];

            pop[i]  = (level_q[i] != '0) && ch_ready_i[i] && !ch_flush_i[i];
            push[i] = ch_hit[i] && !ch_flush_i[i] && ((level_q[i] != FULL_LVL) || pop[i]);

            if (ovf_clr_i[i]) begin
                ovf_d[i] = 1'b0;
            end

            if (ch_flush_i[i]) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                level_d[i]  = '0;
                if (ch_hit[i]) begin
                    wr_err_d = 1'b1;
                end
            end else begin
                if (pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
                end
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = wdata_i;
                    wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    level_d[i] = level_q[i] + LW'(1);
                end else if (!push[i] && pop[i]) begin
                    level_d[i] = level_q[i] - LW'(1);
                end
                // Set beats clear: the overflow branch runs after the clear above.
                if (ch_hit[i] && !push[i]) begin
                    wr_err_d = 1'b1;
                    ovf_d[i] = 1'b1;
                end
            end

            // The head register only refreshes while data remains, so it holds when empty.
            if (level_d[i] != '0) begin
                if (push[i] && (wr_ptr_q[i] == rd_ptr_d[i])) begin
                    head_d[i] = wdata_i;
                end else begin
                    head_d[i] = mem_q[i][rd_ptr_d[i]];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_err_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            ovf_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                level_q[i]  <= '0;
                head_q[i]   <= '0;
            end
        end else begin
            wr_err_q    <= wr_err_d;
            reg_wr_q    <= reg_wr_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                level_q[i]  <= level_d[i];
                head_q[i]   <= head_d[i];
            end
        end
    end

    always_comb begin
        wr_err_o    = wr_err_q;
        reg_wr_o    = reg_wr_q;
        reg_waddr_o = reg_waddr_q;
        reg_wdata_o = reg_wdata_q;
        ovf_sts_o   = ovf_q;
        ch_valid_o  = '0;
        ch_data_o   = '0;
        ch_level_o  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_valid_o[i]                          = (level_q[i] != '0);
            ch_data_o[i*DATA_WIDTH +: DATA_WIDTH]  = head_q[i];
            ch_level_o[i*LW +: LW]                 = level_q[i];
        end
    end

endmodule

// File: tb/tb_lw_sha_wr_admit.sv
// Randomised and directed bench for lw_sha_wr_admit against a queue-based reference model.
module tb_lw_sha_wr_admit;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic              aclk = 1'b0;
    logic              areset;
    logic              wr_i;
    logic [AW-1:0]     waddr_i;
    logic [DW-1:0]     wdata_i;
    logic              wr_err_o;
    logic              reg_wr_o;
    logic [AW-1:0]     reg_waddr_o;
    logic [DW-1:0]     reg_wdata_o;
    logic [NCH-1:0]    ch_valid_o;
    logic [NCH*DW-1:0] ch_data_o;
    logic [NCH-1:0]    ch_ready_i;
    logic [NCH-1:0]    ch_flush_i;
    logic [NCH*LW-1:0] ch_level_o;
    logic [NCH-1:0]    ovf_sts_o;
    logic [NCH-1:0]    ovf_clr_i;

    always #5 aclk = ~aclk;

    lw_sha_wr_admit dut (
        .aclk        (aclk),
        .areset      (areset),
        .wr_i        (wr_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .wr_err_o    (wr_err_o),
        .reg_wr_o    (reg_wr_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o),
        .ch_valid_o  (ch_valid_o),
        .ch_data_o   (ch_data_o),
        .ch_ready_i  (ch_ready_i),
        .ch_flush_i  (ch_flush_i),
        .ch_level_o  (ch_level_o),
        .ovf_sts_o   (ovf_sts_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: each channel is just an ordered list of words.
    logic [DW-1:0] model_q [NCH][$];
    logic [DW-1:0] exp_head [NCH];
    logic          exp_ovf [NCH];
    logic          exp_err;
    logic          exp_reg_wr;
    logic [AW-1:0] exp_reg_addr;
    logic [DW-1:0] exp_reg_data;
    logic [AW-1:0] ch_addr [NCH];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic checkAll();
        checkOutput("wr_err", 32'(wr_err_o), 32'(exp_err));
        checkOutput("reg_wr", 32'(reg_wr_o), 32'(exp_reg_wr));
        checkOutput("reg_waddr", 32'(reg_waddr_o), 32'(exp_reg_addr));
        checkOutput("reg_wdata", reg_wdata_o, exp_reg_data);
        for (int i = 0; i < NCH; i++) begin
            checkOutput($sformatf("ch%0d_valid", i), 32'(ch_valid_o[i]), 32'(model_q[i].size() > 0));
            checkOutput($sformatf("ch%0d_level", i), 32'(ch_level_o[i*LW +: LW]), 32'(model_q[i].size()));
            checkOutput($sformatf("ch%0d_data", i), ch_data_o[i*DW +: DW], exp_head[i]);
            checkOutput($sformatf("ch%0d_ovf", i), 32'(ovf_sts_o[i]), 32'(exp_ovf[i]));
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            model_q[i].delete();
            exp_head[i] = '0;
            exp_ovf[i]  = 1'b0;
        end
        exp_err      = 1'b0;
        exp_reg_wr   = 1'b0;
        exp_reg_addr = '0;
        exp_reg_data = '0;
    endtask

    task automatic modelStep(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [NCH-1:0] ready, input logic [NCH-1:0] flush,
                             input logic [NCH-1:0] clr);
        int target;
        bit popped;
        target = -1;
        for (int i = 0; i < NCH; i++) begin
            if (wr && target < 0 && addr == ch_addr[i]) target = i;
        end
        exp_err    = 1'b0;
        exp_reg_wr = wr && (target < 0);
        if (exp_reg_wr) begin
            exp_reg_addr = addr;
            exp_reg_data = data;
        end
        for (int i = 0; i < NCH; i++) begin
            if (clr[i]) exp_ovf[i] = 1'b0;
            if (flush[i]) begin
                model_q[i].delete();
                if (target == i) exp_err = 1'b1;
            end else begin
                popped = (model_q[i].size() > 0) && ready[i];
                if (popped) void'(model_q[i].pop_front());
                if (target == i) begin
                    if (model_q[i].size() < DEPTH) begin
                        model_q[i].push_back(data);
                    end else begin
                        exp_err    = 1'b1;
                        exp_ovf[i] = 1'b1;
                    end
                end
            end
            if (model_q[i].size() > 0) exp_head[i] = model_q[i][0];
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [NCH-1:0] ready, input logic [NCH-1:0] flush,
                                 input logic [NCH-1:0] clr);
        wr_i       = wr;
        waddr_i    = addr;
        wdata_i    = data;
        ch_ready_i = ready;
        ch_flush_i = flush;
        ovf_clr_i  = clr;
        modelStep(wr, addr, data, ready, flush, clr);
        @(negedge aclk);
        checkAll();
    endtask

    task automatic applyReset();
        areset     = 1'b1;
        wr_i       = 1'b0;
        ch_ready_i = '0;
        ch_flush_i = '0;
        ovf_clr_i  = '0;
        wdata_i    = $urandom;
        modelReset();
        @(negedge aclk);
        areset = 1'b0;
        checkAll();
    endtask

    initial begin
        logic [DW-1:0] exp_order [4];
        logic [AW-1:0] raddr;
        ch_addr[0] = 12'h030;
        ch_addr[1] = 12'h040;
        areset     = 1'b1;
        wr_i       = 1'b0;
        waddr_i    = '0;
        wdata_i    = '0;
        ch_ready_i = '0;
        ch_flush_i = '0;
        ovf_clr_i  = '0;
        @(negedge aclk);
        applyReset();

        // Single word into channel 0.
        applyStimulus(1'b1, 12'h030, 32'hA5A5A5A5, 2'b00, 2'b00, 2'b00);
        applyStimulus(1'b0, 12'h000, 32'h0, 2'b00, 2'b00, 2'b00);
        checkOutput("tp1_valid", 32'(ch_valid_o[0]), 32'd1);
        checkOutput("tp1_data", ch_data_o[31:0], 32'hA5A5A5A5);
        checkOutput("tp1_level", 32'(ch_level_o[2:0]), 32'd1);
        checkOutput("tp1_err", 32'(wr_err_o), 32'd0);
        applyStimulus(1'b0, 12'h000, 32'h0, 2'b01, 2'b00, 2'b00);

        // Fill past capacity: the fifth word overflows.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 12'h030, 32'(k), 2'b00, 2'b00, 2'b00);
        end
        checkOutput("tp2_err", 32'(wr_err_o), 32'd1);
        checkOutput("tp2_ovf", 32'(ovf_sts_o[0]), 32'd1);
        checkOutput("tp2_level", 32'(ch_level_o[2:0]), 32'd4);
        checkOutput("tp2_head", ch_data_o[31:0], 32'd1);

        // Push into a full FIFO while popping: accepted, and order shows pointer wrap.
        applyStimulus(1'b1, 12'h030, 32'd6, 2'b01, 2'b00, 2'b00);
        checkOutput("tp3_err", 32'(wr_err_o), 32'd0);
        checkOutput("tp3_level", 32'(ch_level_o[2:0]), 32'd4);
        exp_order[0] = 32'd2;
        exp_order[1] = 32'd3;
        exp_order[2] = 32'd4;
        exp_order[3] = 32'd6;
        for (int k = 0; k < 4; k++) begin
            checkOutput("tp3_order", ch_data_o[31:0], exp_order[k]);
            applyStimulus(1'b0, 12'h000, 32'h0, 2'b01, 2'b00, 2'b00);
        end
        checkOutput("tp3_empty", 32'(ch_valid_o[0]), 32'd0);

        // Register write pass-through.
        applyStimulus(1'b1, 12'h010, 32'h3, 2'b00, 2'b00, 2'b00);
        checkOutput("tp4_reg_wr", 32'(reg_wr_o), 32'd1);
        checkOutput("tp4_reg_addr", 32'(reg_waddr_o), 32'h010);
        checkOutput("tp4_reg_data", reg_wdata_o, 32'h3);
        checkOutput("tp4_err", 32'(wr_err_o), 32'd0);

        // Flush channel 1 while writing to it; channel 0 untouched.
        applyStimulus(1'b1, 12'h040, 32'h11, 2'b00, 2'b00, 2'b00);
        applyStimulus(1'b1, 12'h040, 32'h12, 2'b00, 2'b00, 2'b00);
        applyStimulus(1'b1, 12'h040, 32'h13, 2'b00, 2'b00, 2'b00);
        applyStimulus(1'b1, 12'h030, 32'h21, 2'b00, 2'b00, 2'b00);
        applyStimulus(1'b1, 12'h040, 32'h99, 2'b00, 2'b10, 2'b00);
        checkOutput("tp5_level1", 32'(ch_level_o[5:3]), 32'd0);
        checkOutput("tp5_err", 32'(wr_err_o), 32'd1);
        checkOutput("tp5_level0", 32'(ch_level_o[2:0]), 32'd1);
        checkOutput("tp5_data0", ch_data_o[31:0], 32'h21);

        // Sticky overflow: set wins over a simultaneous clear.
        applyStimulus(1'b0, 12'h000, 32'h0, 2'b00, 2'b00, 2'b01);
        checkOutput("tp6_clr0", 32'(ovf_sts_o[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 12'h030, 32'h30 + 32'(k), 2'b00, 2'b00, 2'b00);
        end
        checkOutput("tp6_set", 32'(ovf_sts_o[0]), 32'd1);
        applyStimulus(1'b1, 12'h030, 32'h40, 2'b00, 2'b00, 2'b01);
        checkOutput("tp6_set_wins", 32'(ovf_sts_o[0]), 32'd1);
        applyStimulus(1'b0, 12'h000, 32'h0, 2'b00, 2'b00, 2'b01);
        checkOutput("tp6_clr", 32'(ovf_sts_o[0]), 32'd0);

        // Mid-burst reset discards buffered data.
        applyReset();

        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] rdy;
            logic [NCH-1:0] fl;
            logic [NCH-1:0] cl;
            if ($urandom_range(0, 499) == 0) begin
                applyReset();
            end else begin
                case ($urandom_range(0, 3))
                    0: raddr = 12'h030;
                    1: raddr = 12'h040;
                    2: raddr = 12'h010;
                    default: raddr = 12'($urandom);
                endcase
                for (int i = 0; i < NCH; i++) begin
                    rdy[i] = ($urandom_range(0, 2) == 0);
                    fl[i]  = ($urandom_range(0, 31) == 0);
                    cl[i]  = ($urandom_range(0, 15) == 0);
                end
                applyStimulus($urandom_range(0, 3) != 0, raddr, $urandom, rdy, fl, cl);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
